uipt_relay: RTL and testbench
=============================

// Module: uipt_relay
// PURPOSE
// - UART store-and-forward relay: receives serial bytes on i_rx and buffers them in an N-entry
//   byte memory. Once bleng bytes are held, it re-sends them in arrival order on o_tx.
// - Sits between a host UART link and the board's serial port.
// - Used for link/packet loopback tests; the packet length is set by the host.
// PARAMETERS
// - clk_speed  100_000_000  i_clk frequency in Hz
// - baudrate   921_600      serial bit rate; CLKS_PER_BIT = clk_speed/baudrate, integer division (108)
// - D_BITS     8            data bits per frame, LSB first, no parity
// - SP_BITS    1            stop bits per frame (1 or 2)
// - N          400          buffer depth in bytes; pointer width = $clog2(N)
// PORTS
// - i_clk   in   1       system clock, rising edge
// - reset   in   1       asynchronous, active-high reset
// - bleng   in   32      packet length in bytes; sampled when each packet starts
// - i_rx    in   1       serial input, idle high; asynchronous to i_clk
// - o_tx    out  1       serial output, idle high
// BEHAVIOUR
// - Reset values: o_tx=1; FSM=COLLECT; wr_cnt=0; rd_cnt=0; UART idle.
//   Buffer contents are undefined after reset. Reset may assert in any state and aborts any
//   frame in flight; o_tx goes high asynchronously.
// - RX
//   - i_rx passes through a 2-FF synchronizer.
//   - A falling edge on the synchronized line in RX idle starts a frame.
//   - Re-check the line at CLKS_PER_BIT/2; if it is high, the start was a glitch: return to idle.
//   - Sample D_BITS data bits at bit centres, LSB first, then SP_BITS stop bits.
//   - Any stop bit low = framing error: the byte is dropped and no o_dvalid is raised.
//   - A good frame gives a 1-cycle rx_valid pulse with rx_data stable in the same cycle.
// - TX
//   - tx_rdy=1 when idle. A 1-cycle tx_enable while tx_rdy latches i_data.
//   - The frame is 1 start bit (0), then D_BITS LSB first, then SP_BITS ones; each bit lasts
//     exactly CLKS_PER_BIT cycles.
//   - tx_done pulses 1 cycle at the end of the last stop bit. tx_enable while busy is ignored.
// - FSM
//   - COLLECT
//     - On the first rx_valid of a packet, latch len = min(bleng, N).
//     - If len==0, drop the byte, keep wr_cnt=0, stay in COLLECT.
//     - Otherwise write mem[wr_cnt] = rx_data and increment wr_cnt.
//     - When wr_cnt reaches len: go to SEND and clear rd_cnt.
//   - SEND
//     - When tx_rdy is high, pulse tx_enable with mem[rd_cnt] and increment rd_cnt.
//     - After the tx_done for byte len-1: clear wr_cnt and return to COLLECT.
//     - rx_valid during SEND is dropped; the relay is half duplex at packet level.
// - Latency: the first echo start bit begins within 4 i_clk of the rx_valid for the last byte.
//   Back-to-back echoed frames have at most 2 idle cycles between them.
// - A change to bleng mid-packet has no effect until the next packet starts.
// - bleng > N is clamped to N.
// STRUCTURE
// - Package uipt_pkg:
//   - state_t enum {COLLECT, SEND}
//   - function clks_per_bit(clk_speed, baudrate)
// - Sub-module: uart, full-duplex RX+TX. Ports: i_clk, reset, i_rx, i_data, i_tx_enable,
//   o_tx, o_data, o_dvalid, o_tx_rdy, o_tx_done. Same parameters minus N.
// - Buffer: inferred single-clock RAM with a synchronous write port and a registered read port.
// TESTING
// - bleng=5; send 5 random bytes (e.g. A5,3C,00,FF,81) from a bench uart, one every 12 us ->
//   a bench uart on o_tx receives A5,3C,00,FF,81 in order, then o_tx idles high.
// - bleng=1; send 0x5A -> one echoed 0x5A.
//   Measure the start-bit width on o_tx: 108 clocks.
// - bleng=0; send 3 bytes -> o_tx stays high for 100 us.
// - bleng=500 with N=400 -> echo begins after byte 400.
//   A byte sent during SEND is not echoed.
// - Drive a frame with the stop bit forced low, then a good 0x11 with bleng=1 -> only 0x11 echoed.
// - Assert reset mid-echo -> o_tx high immediately.
//   After release, a new bleng=2 packet echoes correctly.

Source files
------------

// File: rtl/uipt_pkg.sv
// Shared types and helpers for the UART store-and-forward relay.
//   state_t      : relay packet FSM (collect bytes / send them back)
//   rx_state_t   : UART receiver frame FSM
//   tx_state_t   : UART transmitter frame FSM
//   clks_per_bit : clock cycles per serial bit (integer division)
package uipt_pkg;

  typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic int clks_per_bit(input int clk_speed, input int baudrate);
    return clk_speed / baudrate;
  endfunction

endpackage

// File: rtl/uart.sv
// Full-duplex UART, LSB first, no parity.
//   i_clk, reset        : clock, async active-high reset
//   i_rx                : serial input (idle high, asynchronous)
//   o_data / o_dvalid   : received byte, 1-cycle valid pulse for good frames
//   i_data / i_tx_enable: byte to send, latched on enable while o_tx_rdy
//   o_tx                : serial output (idle high)
//   o_tx_rdy            : transmitter idle
//   o_tx_done           : 1-cycle pulse after the last stop bit
module uart
  import uipt_pkg::*;
#(
  parameter int clk_speed = 100_000_000,
  parameter int baudrate  = 921_600,
  parameter int D_BITS    = 8,
  parameter int SP_BITS   = 1
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_rx,
  input  logic [D_BITS-1:0] i_data,
  input  logic              i_tx_enable,
  output logic              o_tx,
  output logic [D_BITS-1:0] o_data,
  output logic              o_dvalid,
  output logic              o_tx_rdy,
  output logic              o_tx_done
);

  localparam int CPB = clks_per_bit(clk_speed, baudrate);
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2((D_BITS > SP_BITS ? D_BITS : SP_BITS) + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(D_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(SP_BITS - 1);

  // ---------------- receiver ----------------
  logic              rx_m, rx_s, rx_q;
  rx_state_t         rx_st, rx_st_n;
  logic [CW-1:0]     rx_cnt, rx_cnt_n;
  logic [BW-1:0]     rx_bit, rx_bit_n;
  logic [D_BITS-1:0] rx_sh, rx_sh_n;
  logic              rx_err, rx_err_n, dvalid_n;

  assign o_data = rx_sh;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_q     <= 1'b1;
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_err   <= 1'b0;
      o_dvalid <= 1'b0;
    end else begin
      rx_m     <= i_rx;
      rx_s     <= rx_m;
      rx_q     <= rx_s;
      rx_st    <= rx_st_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_err   <= rx_err_n;
      o_dvalid <= dvalid_n;
    end
  end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + 1'b1;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_err_n = rx_err;
    dvalid_n = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_q && !rx_s) rx_st_n = RX_START;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        // Mid start bit: a high line means the edge was a glitch.
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_err_n = 1'b0;
        rx_st_n  = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == CNT_LAST) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s, rx_sh[D_BITS-1:1]};
        if (rx_bit == DATA_LAST) begin
          rx_bit_n = '0;
          rx_st_n  = RX_STOP;
        end else begin
          rx_bit_n = rx_bit + 1'b1;
        end
      end
      RX_STOP: if (rx_cnt == CNT_LAST) begin
        rx_cnt_n = '0;
        rx_err_n = rx_err | ~rx_s;
        if (rx_bit == STOP_LAST) begin
          rx_st_n  = RX_IDLE;
          dvalid_n = ~(rx_err | ~rx_s);
        end else begin
          rx_bit_n = rx_bit + 1'b1;
        end
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  // ---------------- transmitter ----------------
  tx_state_t         tx_st, tx_st_n;
  logic [CW-1:0]     tx_cnt, tx_cnt_n;
  logic [BW-1:0]     tx_bit, tx_bit_n;
  logic [D_BITS-1:0] tx_sh, tx_sh_n;
  logic              tx_n, done_n;

  assign o_tx_rdy = (tx_st == TX_IDLE);

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      tx_st     <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      tx_st     <= tx_st_n;
      tx_cnt    <= tx_cnt_n;
      tx_bit    <= tx_bit_n;
      tx_sh     <= tx_sh_n;
      o_tx      <= tx_n;
      o_tx_done <= done_n;
    end
  end

  // o_tx is registered: each state drives the level of the *next* bit on its last cycle.
  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + 1'b1;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_n     = o_tx;
    done_n   = 1'b0;
    unique case (tx_st)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_n     = 1'b1;
        if (i_tx_enable) begin
          tx_sh_n = i_data;
          tx_st_n = TX_START;
          tx_n    = 1'b0;
        end
      end
      TX_START: if (tx_cnt == CNT_LAST) begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        tx_st_n  = TX_DATA;
        tx_n     = tx_sh[0];
      end
      TX_DATA: if (tx_cnt == CNT_LAST) begin
        tx_cnt_n = '0;
        if (tx_bit == DATA_LAST) begin
          tx_bit_n = '0;
          tx_st_n  = TX_STOP;
          tx_n     = 1'b1;
        end else begin
          tx_bit_n = tx_bit + 1'b1;
          tx_sh_n  = tx_sh >> 1;
          tx_n     = tx_sh[1];
        end
      end
      TX_STOP: if (tx_cnt == CNT_LAST) begin
        tx_cnt_n = '0;
        if (tx_bit == STOP_LAST) begin
          tx_st_n = TX_IDLE;
          done_n  = 1'b1;
        end else begin
          tx_bit_n = tx_bit + 1'b1;
        end
      end
      default: tx_st_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uipt_relay.sv
// UART store-and-forward relay: collects a packet of min(bleng, N) bytes from
// i_rx, then echoes them in arrival order on o_tx. Half duplex per packet.
//   i_clk, reset : clock, async active-high reset
//   bleng        : packet length, sampled at the first byte of each packet
//   i_rx         : serial input (idle high)
//   o_tx         : serial output (idle high)
module uipt_relay
  import uipt_pkg::*;
#(
  parameter int clk_speed = 100_000_000,
  parameter int baudrate  = 921_600,
  parameter int D_BITS    = 8,
  parameter int SP_BITS   = 1,
  parameter int N         = 400
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic [31:0] bleng,
  input  logic        i_rx,
  output logic        o_tx
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);   // counters must reach N itself
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [D_BITS-1:0] rx_data, tx_data;
  logic              rx_valid, tx_rdy, tx_done, tx_en;

  uart #(
    .clk_speed(clk_speed),
    .baudrate (baudrate),
    .D_BITS   (D_BITS),
    .SP_BITS  (SP_BITS)
  ) u_uart (
    .i_clk      (i_clk),
    .reset      (reset),
    .i_rx       (i_rx),
    .i_data     (tx_data),
    .i_tx_enable(tx_en),
    .o_tx       (o_tx),
    .o_data     (rx_data),
    .o_dvalid   (rx_valid),
    .o_tx_rdy   (tx_rdy),
    .o_tx_done  (tx_done)
  );

  state_t        state, state_n;
  logic [CW-1:0] wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n, len, len_n, pkt_len;
  logic          rd_vld, rd_vld_n, mem_we;

  // Byte buffer: synchronous write, registered read of mem[rd_cnt].
  logic [D_BITS-1:0] mem [N];

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_cnt[AW-1:0]] <= rx_data;
    tx_data <= mem[rd_cnt[AW-1:0]];
  end

  // Length governing the arriving byte: fresh (clamped) bleng at packet start, else latched.
  assign pkt_len = (wr_cnt != '0) ? len
                 : (bleng > 32'(N)) ? N_CNT : bleng[CW-1:0];

  // tx_data lags rd_cnt by one cycle; hold off issuing on SEND entry and right after each issue.
  assign rd_vld_n = (state == SEND) && (state_n == SEND) && !tx_en;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state  <= COLLECT;
      wr_cnt <= '0;
      rd_cnt <= '0;
      len    <= '0;
      rd_vld <= 1'b0;
    end else begin
      state  <= state_n;
      wr_cnt <= wr_cnt_n;
      rd_cnt <= rd_cnt_n;
      len    <= len_n;
      rd_vld <= rd_vld_n;
    end
  end

  always_comb begin
    state_n  = state;
    wr_cnt_n = wr_cnt;
    rd_cnt_n = rd_cnt;
    len_n    = len;
    mem_we   = 1'b0;
    tx_en    = 1'b0;
    unique case (state)
      COLLECT: if (rx_valid && pkt_len != '0) begin
        len_n    = pkt_len;
        mem_we   = 1'b1;
        wr_cnt_n = wr_cnt + 1'b1;
        if (wr_cnt + 1'b1 == pkt_len) begin
          state_n  = SEND;
          rd_cnt_n = '0;
        end
      end
      SEND: begin
        // rx_valid is ignored here: bytes arriving while echoing are dropped.
        if (tx_rdy && rd_vld && rd_cnt != len) begin
          tx_en    = 1'b1;
          rd_cnt_n = rd_cnt + 1'b1;
        end else if (tx_done && rd_cnt == len) begin
          state_n  = COLLECT;
          wr_cnt_n = '0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_uipt_relay.sv
// Self-checking bench for uipt_relay. A bit-banged serial driver feeds i_rx, a
// serial decoder on o_tx collects echoed bytes, and a packet-level model
// (queues) predicts which bytes must come back. Buffer depth is reduced to 12
// so the clamp case stays short; the bit time stays at 108 clocks.
module tb_uipt_relay;

  localparam int CPB = 108;   // 100 MHz / 921600 baud
  localparam int N   = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [31:0] bleng = '0;

  uipt_relay #(.N(N)) dut (
    .i_clk(clk),
    .reset(rst),
    .bleng(bleng),
    .i_rx (rx),
    .o_tx (tx)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$], pend[$], got[$];
  int         m_cnt = 0, m_len = 0, m_echoed = 0, rst_epoch = 0;
  bit         m_send = 1'b0, mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Packet model: called once per good frame the bench sends.
  function automatic void model_rx(input logic [7:0] b);
    if (m_send) return;
    if (m_cnt == 0) m_len = (bleng > 32'(N)) ? N : int'(bleng);
    if (m_len == 0) return;
    pend.push_back(b);
    m_cnt++;
    if (m_cnt == m_len) begin
      while (pend.size() != 0) exp_q.push_back(pend.pop_front());
      m_send   = 1'b1;
      m_echoed = 0;
    end
  endfunction

  // Serial driver; the model is told about the byte at mid stop bit, before the echo can start.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = ~bad_stop;
    repeat (CPB / 2) @(negedge clk);
    if (!bad_stop) model_rx(b);
    repeat (CPB - CPB / 2) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_got(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 30000) begin
      @(negedge clk);
      k++;
    end
    check(name, got.size(), n);
  endtask

  // Decoder on o_tx; compares every echoed byte against the model.
  initial begin : echo_rx
    logic [7:0] d;
    logic       sb, pb;
    int         ep;
    forever begin
      @(negedge tx);
      ep = rst_epoch;
      repeat (CPB / 2) @(posedge clk);
      #1 sb = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 d[i] = tx;
      end
      repeat (CPB) @(posedge clk);
      #1 pb = tx;
      if (ep == rst_epoch && !rst) begin
        check("echo_start_bit", sb, 1'b0);
        check("echo_stop_bit", pb, 1'b1);
        got.push_back(d);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL echo_unexpected: got 0x%0h, want none", d);
        end else begin
          check("echo_data", d, exp_q.pop_front());
          m_echoed++;
          if (m_echoed >= m_len) begin
            m_send = 1'b0;
            m_cnt  = 0;
          end
        end
      end
    end
  end

  // Whenever no echo is owed, the line must idle high.
  always @(negedge clk)
    if (mon_on && !rst && !m_send) check("tx_idle", tx, 1'b1);

  initial begin : main
    logic [7:0] t1 [5];
    int         base, w, k;
    t1 = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81};

    repeat (5) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_tx", tx, 1'b1);

    // 5-byte packet, one byte every 12 us
    bleng = 5;
    base  = got.size();
    foreach (t1[i]) begin
      send_byte(t1[i]);
      repeat (120) @(negedge clk);
    end
    wait_got(base + 5, "t1_echo_count");
    foreach (t1[i]) check("t1_byte", got[base+i], t1[i]);
    repeat (300) @(negedge clk);

    // Single byte; 0x5A has bit0 = 0 so the first low run is start bit + bit0
    bleng = 1;
    base  = got.size();
    k = 0;
    w = 0;
    fork
      send_byte(8'h5A);
      begin
        while (tx && k < 5000) begin
          @(negedge clk);
          k++;
        end
        while (!tx && w < 1000) begin
          @(negedge clk);
          w++;
        end
      end
    join
    check("t2_start_plus_d0_width", w, 216);
    wait_got(base + 1, "t2_echo_count");
    check("t2_byte", got[base], 8'h5A);
    repeat (300) @(negedge clk);

    // Zero length: nothing may come back for 100 us
    bleng = 0;
    base  = got.size();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    repeat (10000) @(negedge clk);
    check("t3_no_echo", got.size() - base, 0);

    // Oversized length clamps to N; a byte sent while echoing is dropped
    bleng = 500;
    base  = got.size();
    for (int i = 0; i < N - 1; i++) send_byte(8'(32 + i * 7));
    repeat (200) @(negedge clk);
    check("t4_no_echo_before_full", got.size() - base, 0);
    send_byte(8'hC8);
    wait_got(base + 1, "t4_echo_started");
    send_byte(8'hEE);
    wait_got(base + N, "t4_echo_count");
    repeat (2000) @(negedge clk);
    check("t4_total_echo", got.size() - base, N);
    check("t4_first", got[base], 8'h20);
    check("t4_last", got[base+N-1], 8'hC8);

    // Framing error then a good byte
    bleng = 1;
    base  = got.size();
    send_byte(8'h77, 1'b1);
    repeat (300) @(negedge clk);
    send_byte(8'h11);
    wait_got(base + 1, "t5_echo_count");
    repeat (1500) @(negedge clk);
    check("t5_only_one", got.size() - base, 1);
    check("t5_byte", got[base], 8'h11);

    // Reset in the middle of an echo of 0x00 (line low), then a fresh packet
    bleng = 2;
    base  = got.size();
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (300) @(negedge clk);
    check("t6_echo_in_flight", tx, 1'b0);
    rst = 1'b1;
    rst_epoch++;
    exp_q.delete();
    pend.delete();
    m_send   = 1'b0;
    m_cnt    = 0;
    m_echoed = 0;
    #1 check("t6_reset_tx_async", tx, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    send_byte(8'hC3);
    send_byte(8'h3C);
    wait_got(base + 2, "t6_echo_count");
    check("t6_b0", got[base], 8'hC3);
    check("t6_b1", got[base+1], 8'h3C);
    repeat (300) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
